// File: rtl/alarm_controller.sv
// ============================================================================
// Module  : alarm_controller
// Purpose : Alarm arm/ring/snooze/stop sequencer and buzzer tone generator.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_controller #(
  parameter int BEEP_HALF   = 25000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [4:0] alm_hr,
  input  logic [5:0] alm_min,
  input  logic       alarm,
  input  logic       snooze,
  input  logic       stop,
  output logic       ringring,
  output logic       ringing,
  output logic       snoozing,
  output logic       armed
);

  localparam int RW = (RING_SECS   > 1) ? $clog2(RING_SECS)   : 1;
  localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
  localparam int TW = (BEEP_HALF   > 1) ? $clog2(BEEP_HALF)   : 1;
  localparam int UW = (MAX_SNOOZE  > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [RW-1:0] c_ring_last = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] c_snz_last  = SW'(SNOOZE_SECS - 1);
  localparam logic [TW-1:0] c_tone_last = TW'(BEEP_HALF - 1);
  localparam logic [UW-1:0] c_max_snz   = UW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [RW-1:0] r_ring_cnt, w_nxt_ring_cnt;
  logic [SW-1:0] r_snz_cnt, w_nxt_snz_cnt;
  logic [UW-1:0] r_snz_used, w_nxt_snz_used;
  logic [TW-1:0] r_tone_cnt, w_nxt_tone_cnt;
  logic          r_tone, w_nxt_tone;
  logic          r_match_done, w_nxt_match_done;
  logic          w_arm_to_ring;

  logic r_alarm_s1, r_alarm_s2;
  logic r_snooze_s1, r_snooze_s2, r_snooze_s3;
  logic r_stop_s1, r_stop_s2, r_stop_s3;
  logic r_ringring, r_ringing, r_snoozing, r_armed;

  logic w_alarm_sync, w_snooze_p, w_stop_p, w_match;

  assign w_alarm_sync = r_alarm_s2;
  assign w_snooze_p   = r_snooze_s2 & ~r_snooze_s3;
  assign w_stop_p     = r_stop_s2 & ~r_stop_s3;
  assign w_match      = (cur_hr == alm_hr) && (cur_min == alm_min);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_ring_cnt = r_ring_cnt;
    w_nxt_snz_cnt  = r_snz_cnt;
    w_nxt_snz_used = r_snz_used;
    w_arm_to_ring  = 1'b0;
    w_nxt_tone_cnt = '0;
    w_nxt_tone     = 1'b0;

    if (!w_alarm_sync) begin
      w_nxt_state    = ST_IDLE;
      w_nxt_ring_cnt = '0;
      w_nxt_snz_cnt  = '0;
      w_nxt_snz_used = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_nxt_state = ST_ARMED;
        ST_ARMED: begin
          if (w_match && !r_match_done) begin
            w_nxt_state    = ST_RINGING;
            w_nxt_ring_cnt = '0;
            w_nxt_snz_used = '0;
            w_arm_to_ring  = 1'b1;
          end
        end
        ST_RINGING: begin
          // Buttons take precedence over a coincident second tick.
          if (w_stop_p) begin
            w_nxt_state    = ST_ARMED;
            w_nxt_ring_cnt = '0;
            w_nxt_snz_cnt  = '0;
          end else if (w_snooze_p && (r_snz_used < c_max_snz)) begin
            w_nxt_state    = ST_SNOOZE;
            w_nxt_ring_cnt = '0;
            w_nxt_snz_cnt  = '0;
            w_nxt_snz_used = r_snz_used + 1'b1;
          end else if (sec_tick) begin
            if (r_ring_cnt == c_ring_last) begin
              w_nxt_state    = ST_ARMED;
              w_nxt_ring_cnt = '0;
            end else begin
              w_nxt_ring_cnt = r_ring_cnt + 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (w_stop_p) begin
            w_nxt_state    = ST_ARMED;
            w_nxt_ring_cnt = '0;
            w_nxt_snz_cnt  = '0;
          end else if (sec_tick) begin
            if (r_snz_cnt == c_snz_last) begin
              w_nxt_state    = ST_RINGING;
              w_nxt_ring_cnt = '0;
              w_nxt_snz_cnt  = '0;
            end else begin
              w_nxt_snz_cnt = r_snz_cnt + 1'b1;
            end
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end

    // Tone phase restarts on every entry into RINGING.
    if ((r_state == ST_RINGING) && (w_nxt_state == ST_RINGING)) begin
      if (r_tone_cnt == c_tone_last) begin
        w_nxt_tone_cnt = '0;
        w_nxt_tone     = ~r_tone;
      end else begin
        w_nxt_tone_cnt = r_tone_cnt + 1'b1;
        w_nxt_tone     = r_tone;
      end
    end

    w_nxt_match_done = w_match ? (r_match_done | w_arm_to_ring) : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm_s1   <= 1'b0;
      r_alarm_s2   <= 1'b0;
      r_snooze_s1  <= 1'b0;
      r_snooze_s2  <= 1'b0;
      r_snooze_s3  <= 1'b0;
      r_stop_s1    <= 1'b0;
      r_stop_s2    <= 1'b0;
      r_stop_s3    <= 1'b0;
      r_state      <= ST_IDLE;
      r_ring_cnt   <= '0;
      r_snz_cnt    <= '0;
      r_snz_used   <= '0;
      r_tone_cnt   <= '0;
      r_tone       <= 1'b0;
      r_match_done <= 1'b0;
      r_ringring   <= 1'b0;
      r_ringing    <= 1'b0;
      r_snoozing   <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_alarm_s1   <= alarm;
      r_alarm_s2   <= r_alarm_s1;
      r_snooze_s1  <= snooze;
      r_snooze_s2  <= r_snooze_s1;
      r_snooze_s3  <= r_snooze_s2;
      r_stop_s1    <= stop;
      r_stop_s2    <= r_stop_s1;
      r_stop_s3    <= r_stop_s2;
      r_state      <= w_nxt_state;
      r_ring_cnt   <= w_nxt_ring_cnt;
      r_snz_cnt    <= w_nxt_snz_cnt;
      r_snz_used   <= w_nxt_snz_used;
      r_tone_cnt   <= w_nxt_tone_cnt;
      r_tone       <= w_nxt_tone;
      r_match_done <= w_nxt_match_done;
      // 1 s on / 1 s off cadence, sounding during even ring seconds.
      r_ringring   <= (w_nxt_state == ST_RINGING) & w_nxt_tone & ~w_nxt_ring_cnt[0];
      r_ringing    <= (w_nxt_state == ST_RINGING);
      r_snoozing   <= (w_nxt_state == ST_SNOOZE);
      r_armed      <= (w_nxt_state != ST_IDLE);
    end
  end

  assign ringring = r_ringring;
  assign ringing  = r_ringing;
  assign snoozing = r_snoozing;
  assign armed    = r_armed;

endmodule

`default_nettype wire
